// File: rtl/dplca_pkg.sv
// Shared DPLCA definitions: claim encodings, claim ordering/aging helpers, and
// the claim-table producer state encoding.
package dplca_pkg;

  localparam logic [1:0] CLAIM_NONE = 2'b00;
  localparam logic [1:0] CLAIM_SOFT = 2'b01;
  localparam logic [1:0] CLAIM_HARD = 2'b10;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SYNC     = 2'd1,
    ST_COLLECT  = 2'd2
  } dplca_state_t;

  // HARD > SOFT > NONE; the unused code 2'b11 ranks as NONE.
  function automatic logic [1:0] claim_max(input logic [1:0] a, input logic [1:0] b);
    if (a == CLAIM_HARD || b == CLAIM_HARD) return CLAIM_HARD;
    if (a == CLAIM_SOFT || b == CLAIM_SOFT) return CLAIM_SOFT;
    return CLAIM_NONE;
  endfunction

  function automatic logic [1:0] claim_age(input logic [1:0] c);
    return (c == CLAIM_HARD) ? CLAIM_SOFT : CLAIM_NONE;
  endfunction

  function automatic logic claim_valid(input logic [1:0] c);
    return (c == CLAIM_SOFT) || (c == CLAIM_HARD);
  endfunction

endpackage

// File: rtl/dplca_claim_entry.sv
// One claim-table slot: a 2-bit claim plus the refresh bit that shields it
// from the next aging boundary.
module dplca_claim_entry
  import dplca_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       set_en,
  input  logic [1:0] set_claim,
  input  logic       age_stb,
  output logic [1:0] entry
);

  logic       refresh;
  logic [1:0] entry_set;
  logic       refresh_set;

  // A claim on the same clock as an aging boundary lands first, so it also protects.
  always_comb begin
    entry_set   = entry;
    refresh_set = refresh;
    if (set_en) begin
      entry_set = claim_max(entry, set_claim);
      if (claim_valid(set_claim)) refresh_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry   <= CLAIM_NONE;
      refresh <= 1'b0;
    end else if (clear) begin
      entry   <= CLAIM_NONE;
      refresh <= 1'b0;
    end else if (age_stb) begin
      entry   <= refresh_set ? entry_set : claim_age(entry_set);
      refresh <= 1'b0;
    end else begin
      entry   <= entry_set;
      refresh <= refresh_set;
    end
  end

endmodule

// File: rtl/dplca_txop_claim_table.sv
// DPLCA claim-table producer: records per-node claims seen in each TXOP, ages
// them every DPLCA_AGING_CYCLES PLCA cycles and reports per-cycle updates.
module dplca_txop_claim_table
  import dplca_pkg::*;
#(
  parameter int unsigned DPLCA_AGING_CYCLES = 128
) (
  input  logic         clk,
  input  logic         plca_reset_n,
  input  logic         dplca_en,
  input  logic         dplca_aging,
  input  logic         beacon_strobe,
  input  logic         txop_end_strobe,
  input  logic [7:0]   txop_cur_id,
  input  logic [1:0]   txop_claim,
  output logic [511:0] txop_claim_table_unpacked,
  output logic         dplca_txop_table_upd,
  output logic         dplca_new_age,
  output logic [7:0]   dplca_txop_id,
  output logic [7:0]   dplca_txop_node_count
);

  localparam logic [7:0] AGE_LAST = 8'(DPLCA_AGING_CYCLES - 1);

  dplca_state_t state, state_nxt;
  logic [7:0]   cyc_cnt;
  logic [7:0]   max_id;
  logic [7:0]   max_eff;
  logic         txop_v;
  logic         bcn_v;
  logic         boundary;

  always_ff @(posedge clk or negedge plca_reset_n) begin
    if (!plca_reset_n) state <= ST_DISABLED;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_DISABLED: state_nxt = ST_SYNC;
      ST_SYNC:     if (beacon_strobe) state_nxt = ST_COLLECT;
      ST_COLLECT:  state_nxt = ST_COLLECT;
      default:     state_nxt = ST_DISABLED;
    endcase
    if (!dplca_en) state_nxt = ST_DISABLED;
  end

  assign txop_v   = (state == ST_COLLECT) && txop_end_strobe;
  assign bcn_v    = (state == ST_COLLECT) && beacon_strobe;
  assign boundary = bcn_v && dplca_aging && (cyc_cnt == AGE_LAST);

  // A TXOP closing on the beacon clock still belongs to the ending cycle.
  assign max_eff = (txop_v && (txop_cur_id > max_id)) ? txop_cur_id : max_id;

  always_ff @(posedge clk or negedge plca_reset_n) begin
    if (!plca_reset_n) begin
      cyc_cnt               <= '0;
      max_id                <= '0;
      dplca_txop_table_upd  <= 1'b0;
      dplca_new_age         <= 1'b0;
      dplca_txop_id         <= '0;
      dplca_txop_node_count <= '0;
    end else if (!dplca_en) begin
      cyc_cnt               <= '0;
      max_id                <= '0;
      dplca_txop_table_upd  <= 1'b0;
      dplca_new_age         <= 1'b0;
      dplca_txop_id         <= '0;
      dplca_txop_node_count <= '0;
    end else begin
      dplca_txop_table_upd <= txop_v | bcn_v;
      if (bcn_v) begin
        dplca_txop_id         <= '0;
        dplca_txop_node_count <= (max_eff == 8'hFF) ? 8'hFF : max_eff + 8'd1;
        max_id                <= '0;
      end else if (txop_v) begin
        dplca_txop_id <= txop_cur_id;
        max_id        <= max_eff;
      end
      if (!dplca_aging) begin
        cyc_cnt       <= '0;
        dplca_new_age <= 1'b0;
      end else if (bcn_v) begin
        cyc_cnt       <= boundary ? '0 : cyc_cnt + 8'd1;
        dplca_new_age <= boundary;
      end
    end
  end

  for (genvar n = 0; n < 256; n++) begin : g_entry
    dplca_claim_entry u_entry (
      .clk       (clk),
      .rst_n     (plca_reset_n),
      .clear     (!dplca_en),
      .set_en    (txop_v && (txop_cur_id == 8'(n))),
      .set_claim (txop_claim),
      .age_stb   (boundary),
      .entry     (txop_claim_table_unpacked[2*n +: 2])
    );
  end

endmodule

// File: tb/tb_dplca_txop_claim_table.sv
// Scoreboard bench for dplca_txop_claim_table with a two-cycle aging period:
// directed strobes push expected upd contents, a monitor checks each upd pulse.
module tb_dplca_txop_claim_table;

  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] SOFT = 2'b01;
  localparam logic [1:0] HARD = 2'b10;

  logic         clk = 1'b0;
  logic         plca_reset_n;
  logic         dplca_en;
  logic         dplca_aging;
  logic         beacon_strobe;
  logic         txop_end_strobe;
  logic [7:0]   txop_cur_id;
  logic [1:0]   txop_claim;
  logic [511:0] tbl;
  logic         upd;
  logic         new_age;
  logic [7:0]   txop_id;
  logic [7:0]   node_count;

  typedef struct {
    logic [7:0]  id;
    logic [7:0]  nc;
    logic        na;
    int unsigned idx;
    logic [1:0]  val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  dplca_txop_claim_table #(.DPLCA_AGING_CYCLES(2)) dut (
    .clk                       (clk),
    .plca_reset_n              (plca_reset_n),
    .dplca_en                  (dplca_en),
    .dplca_aging               (dplca_aging),
    .beacon_strobe             (beacon_strobe),
    .txop_end_strobe           (txop_end_strobe),
    .txop_cur_id               (txop_cur_id),
    .txop_claim                (txop_claim),
    .txop_claim_table_unpacked (tbl),
    .dplca_txop_table_upd      (upd),
    .dplca_new_age             (new_age),
    .dplca_txop_id             (txop_id),
    .dplca_txop_node_count     (node_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic txop(input logic [7:0] id, input logic [1:0] c, input logic [7:0] nc,
                      input logic na, input int unsigned idx, input logic [1:0] val);
    txop_cur_id     = id;
    txop_claim      = c;
    txop_end_strobe = 1'b1;
    sb.push_back('{id, nc, na, idx, val});
    tick(1);
    txop_end_strobe = 1'b0;
    txop_claim      = NONE;
  endtask

  task automatic beacon(input logic [7:0] nc, input logic na, input int unsigned idx,
                        input logic [1:0] val);
    beacon_strobe = 1'b1;
    sb.push_back('{8'd0, nc, na, idx, val});
    tick(1);
    beacon_strobe = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (plca_reset_n && upd) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_upd: got upd=1 txop_id=%0d, expected no pulse", txop_id);
        end else begin
          e = sb.pop_front();
          check("upd_txop_id", {24'd0, txop_id}, {24'd0, e.id});
          check("upd_node_count", {24'd0, node_count}, {24'd0, e.nc});
          check("upd_new_age", {31'd0, new_age}, {31'd0, e.na});
          check($sformatf("upd_entry%0d", e.idx), {30'd0, tbl[2*e.idx +: 2]}, {30'd0, e.val});
        end
      end
    end
  endtask

  initial begin
    plca_reset_n    = 1'b0;
    dplca_en        = 1'b0;
    dplca_aging     = 1'b0;
    beacon_strobe   = 1'b0;
    txop_end_strobe = 1'b0;
    txop_cur_id     = '0;
    txop_claim      = NONE;
    fork
      monitor();
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    tick(3);
    check("rst_table", $countones(tbl), 0);
    check("rst_upd", {31'd0, upd}, 0);
    check("rst_node_count", {24'd0, node_count}, 0);
    check("rst_new_age", {31'd0, new_age}, 0);

    plca_reset_n = 1'b1;
    dplca_en     = 1'b1;
    tick(2);
    // SYNC beacon: enters COLLECT, no upd
    beacon_strobe = 1'b1;
    tick(1);
    beacon_strobe = 1'b0;
    tick(1);

    txop(8'd3, HARD, 8'd0, 1'b0, 3, HARD);
    tick(2);
    beacon(8'd4, 1'b0, 3, HARD);
    tick(2);

    // Colliding strobes: one upd with id 0, TXOP 9 counted in the closing cycle
    txop_cur_id     = 8'd9;
    txop_claim      = HARD;
    txop_end_strobe = 1'b1;
    beacon_strobe   = 1'b1;
    sb.push_back('{8'd0, 8'd10, 1'b0, 9, HARD});
    tick(1);
    txop_end_strobe = 1'b0;
    beacon_strobe   = 1'b0;
    txop_claim      = NONE;
    tick(2);

    dplca_aging = 1'b1;
    tick(1);
    txop(8'd5, HARD, 8'd10, 1'b0, 5, HARD);
    txop(8'd6, SOFT, 8'd10, 1'b0, 6, SOFT);
    txop(8'd7, HARD, 8'd10, 1'b0, 7, HARD);
    beacon(8'd8, 1'b0, 5, HARD);
    txop(8'd7, HARD, 8'd8, 1'b0, 7, HARD);
    beacon(8'd8, 1'b1, 5, HARD);   // boundary 1: everything still refreshed
    txop(8'd7, HARD, 8'd8, 1'b1, 6, SOFT);
    beacon(8'd8, 1'b0, 5, HARD);
    txop(8'd7, HARD, 8'd8, 1'b0, 7, HARD);
    beacon(8'd8, 1'b1, 5, SOFT);   // boundary 2: 5 HARD->SOFT, 6 SOFT->NONE
    txop(8'd7, HARD, 8'd8, 1'b1, 6, NONE);
    beacon(8'd8, 1'b0, 5, SOFT);
    txop(8'd7, HARD, 8'd8, 1'b0, 7, HARD);
    beacon(8'd8, 1'b1, 5, NONE);   // boundary 3: 5 SOFT->NONE, 7 kept
    txop(8'd7, HARD, 8'd8, 1'b1, 7, HARD);

    dplca_aging = 1'b0;
    tick(1);
    check("aging_off_new_age", {31'd0, new_age}, 0);
    for (int k = 0; k < 3; k++) begin
      beacon((k == 0) ? 8'd8 : 8'd1, 1'b0, 7, HARD);
      tick(100);
    end

    dplca_en = 1'b0;
    tick(1);
    check("dis_table", $countones(tbl), 0);
    check("dis_upd", {31'd0, upd}, 0);
    check("dis_node_count", {24'd0, node_count}, 0);
    check("dis_txop_id", {24'd0, txop_id}, 0);
    // Strobe on the clock that leaves DISABLED must be ignored
    dplca_en        = 1'b1;
    txop_cur_id     = 8'd4;
    txop_claim      = HARD;
    txop_end_strobe = 1'b1;
    tick(1);
    txop_end_strobe = 1'b0;
    txop_claim      = NONE;
    tick(3);
    check("dis_strobe_table", $countones(tbl), 0);

    beacon_strobe = 1'b1;
    tick(1);
    beacon_strobe = 1'b0;
    tick(1);
    txop(8'd2, HARD, 8'd0, 1'b0, 2, HARD);
    tick(2);

    // Async reset in mid-COLLECT while an upd pulse is showing
    txop_cur_id     = 8'd2;
    txop_claim      = SOFT;
    txop_end_strobe = 1'b1;
    @(posedge clk);
    #2;
    txop_end_strobe = 1'b0;
    check("pre_rst_upd", {31'd0, upd}, 1);
    check("pre_rst_entry2", {30'd0, tbl[5:4]}, {30'd0, HARD});
    plca_reset_n = 1'b0;
    #1;
    check("async_rst_table", $countones(tbl), 0);
    check("async_rst_upd", {31'd0, upd}, 0);
    check("async_rst_new_age", {31'd0, new_age}, 0);
    tick(2);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
